// File: rtl/fsm_control_multi_pkg.sv
// ----------------------------------------------------------------------------
// fsm_ctrl_pkg
// Shared definitions for the multi-FIFO flow-control supervisor:
//   STATE_W            width of the encoded state (debug output)
//   ST_RESET..ST_ERROR fixed state encoding visible on the state output
//   state_t            enum built on that encoding, used by the FSM
// ----------------------------------------------------------------------------
package fsm_ctrl_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_RESET  = 3'd0;
  localparam logic [STATE_W-1:0] ST_INIT   = 3'd1;
  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd2;
  localparam logic [STATE_W-1:0] ST_ACTIVE = 3'd3;
  localparam logic [STATE_W-1:0] ST_ERROR  = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    S_RESET  = ST_RESET,
    S_INIT   = ST_INIT,
    S_IDLE   = ST_IDLE,
    S_ACTIVE = ST_ACTIVE,
    S_ERROR  = ST_ERROR
  } state_t;

endpackage

// File: rtl/fsm_control_multi_if.sv
// ----------------------------------------------------------------------------
// fsm_control_multi_if
// Bundles the configuration, FIFO status and supervisor status signals.
//   master : configuration source / FIFO bank side (drives init, thresholds,
//            FIFO_error, FIFO_empty; observes status)
//   slave  : the supervisor (fsm_control_multi)
// Handshake: there is no valid/ready pair; every input is a level sampled on
// each rising clock edge, and every output is a registered level that changes
// only on that edge (or immediately on reset).
// ----------------------------------------------------------------------------
interface fsm_control_multi_if #(
  parameter int NUM_FIFOS = 4,
  parameter int TH_WIDTH  = 4
);
  import fsm_ctrl_pkg::*;

  logic                 init;
  logic [TH_WIDTH-1:0]  umbral_afull;
  logic [TH_WIDTH-1:0]  umbral_aempty;
  logic [NUM_FIFOS-1:0] FIFO_error;
  logic [NUM_FIFOS-1:0] FIFO_empty;

  logic [TH_WIDTH-1:0]  umbrales_afull;
  logic [TH_WIDTH-1:0]  umbrales_aempty;
  logic                 idle;
  logic                 active;
  logic                 error;
  logic                 cfg_err;
  logic [NUM_FIFOS-1:0] error_src;
  logic [STATE_W-1:0]   state;

  modport master (
    output init, umbral_afull, umbral_aempty, FIFO_error, FIFO_empty,
    input  umbrales_afull, umbrales_aempty, idle, active, error, cfg_err,
           error_src, state
  );

  modport slave (
    input  init, umbral_afull, umbral_aempty, FIFO_error, FIFO_empty,
    output umbrales_afull, umbrales_aempty, idle, active, error, cfg_err,
           error_src, state
  );

endinterface

// File: rtl/fsm_control_multi_err_capture.sv
// ----------------------------------------------------------------------------
// fsm_ctrl_err_capture
// Sticky record of which FIFOs reported an error.
//   clk, reset     clock, asynchronous active-high reset
//   i_capture      load o_error_src with i_fifo_error (entry into ERROR)
//   i_accum        OR i_fifo_error into o_error_src (while in ERROR)
//   i_clear        clear o_error_src (leaving ERROR via init); highest priority
//   i_fifo_error   per-FIFO error levels
//   o_error_src    registered sticky error record
// ----------------------------------------------------------------------------
module fsm_ctrl_err_capture #(
  parameter int NUM_FIFOS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_capture,
  input  logic                 i_accum,
  input  logic                 i_clear,
  input  logic [NUM_FIFOS-1:0] i_fifo_error,
  output logic [NUM_FIFOS-1:0] o_error_src
);

  logic [NUM_FIFOS-1:0] r_error_src;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_error_src <= '0;
    end else if (i_clear) begin
      r_error_src <= '0;
    end else if (i_capture) begin
      r_error_src <= i_fifo_error;
    end else if (i_accum) begin
      r_error_src <= r_error_src | i_fifo_error;
    end
  end

  assign o_error_src = r_error_src;

endmodule

// File: rtl/fsm_control_multi.sv
// ----------------------------------------------------------------------------
// fsm_control_multi
// Flow-control supervisor for NUM_FIFOS virtual-channel FIFOs. Latches the
// almost-full / almost-empty thresholds while init is high, validates them,
// then tracks IDLE (all FIFOs empty) / ACTIVE and traps FIFO errors in ERROR.
//   clk    system clock
//   reset  asynchronous, active-high
//   bus    fsm_control_multi_if.slave: init, umbral_afull/aempty, FIFO_error,
//          FIFO_empty in; umbrales_afull/aempty, idle, active, error, cfg_err,
//          error_src, state out (all registered)
// ERR_EXIT_INIT = 1 lets init leave ERROR; 0 means only reset leaves ERROR.
// ----------------------------------------------------------------------------
module fsm_control_multi
  import fsm_ctrl_pkg::*;
#(
  parameter int NUM_FIFOS     = 4,
  parameter int TH_WIDTH      = 4,
  parameter bit ERR_EXIT_INIT = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  fsm_control_multi_if.slave     bus
);

  state_t               r_state;
  state_t               w_next;
  logic [TH_WIDTH-1:0]  r_afull;
  logic [TH_WIDTH-1:0]  r_aempty;
  logic [TH_WIDTH-1:0]  w_afull_nxt;
  logic [TH_WIDTH-1:0]  w_aempty_nxt;
  logic                 r_idle;
  logic                 r_active;
  logic                 r_error;
  logic                 r_cfg_err;
  logic                 w_cfg_nxt;
  logic                 w_capture;
  logic                 w_accum;
  logic                 w_clear;
  logic                 w_any_err;
  logic                 w_all_empty;
  logic [NUM_FIFOS-1:0] w_error_src;

  assign w_any_err   = |bus.FIFO_error;
  assign w_all_empty = &bus.FIFO_empty;

  // Next state, next thresholds and error-capture strobes.
  // Priority outside INIT: FIFO error > init > empty status.
  always_comb begin
    w_next       = r_state;
    w_afull_nxt  = r_afull;
    w_aempty_nxt = r_aempty;
    w_cfg_nxt    = r_cfg_err;
    w_capture    = 1'b0;
    w_accum      = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      S_RESET: w_next = S_INIT;
      S_INIT: begin
        // FIFO_error is deliberately not looked at while configuring.
        if (bus.init) begin
          w_afull_nxt  = bus.umbral_afull;
          w_aempty_nxt = bus.umbral_aempty;
        end else if (r_aempty >= r_afull) begin
          w_next    = S_ERROR;
          w_cfg_nxt = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_IDLE, S_ACTIVE: begin
        if (w_any_err) begin
          w_next    = S_ERROR;
          w_capture = 1'b1;
        end else if (bus.init) begin
          w_next = S_INIT;
        end else if (!w_all_empty) begin
          w_next = S_ACTIVE;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ERROR: begin
        w_accum = 1'b1;
        // A live FIFO error outranks init, so the exit waits for it to drop.
        if (!w_any_err && ERR_EXIT_INIT && bus.init) begin
          w_next    = S_INIT;
          w_clear   = 1'b1;
          w_cfg_nxt = 1'b0;
        end
      end
      default: w_next = S_RESET;
    endcase
  end

  // Status flags are registered from the next state so they change on the
  // same edge as the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_RESET;
      r_afull   <= '0;
      r_aempty  <= '0;
      r_idle    <= 1'b0;
      r_active  <= 1'b0;
      r_error   <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_afull   <= w_afull_nxt;
      r_aempty  <= w_aempty_nxt;
      r_idle    <= (w_next == S_IDLE);
      r_active  <= (w_next == S_ACTIVE);
      r_error   <= (w_next == S_ERROR);
      r_cfg_err <= w_cfg_nxt;
    end
  end

  fsm_ctrl_err_capture #(
    .NUM_FIFOS (NUM_FIFOS)
  ) u_err_capture (
    .clk          (clk),
    .reset        (reset),
    .i_capture    (w_capture),
    .i_accum      (w_accum),
    .i_clear      (w_clear),
    .i_fifo_error (bus.FIFO_error),
    .o_error_src  (w_error_src)
  );

  assign bus.umbrales_afull  = r_afull;
  assign bus.umbrales_aempty = r_aempty;
  assign bus.idle            = r_idle;
  assign bus.active          = r_active;
  assign bus.error           = r_error;
  assign bus.cfg_err         = r_cfg_err;
  assign bus.error_src       = w_error_src;
  assign bus.state           = r_state;

endmodule

// File: tb/tb_fsm_control_multi.sv
// ----------------------------------------------------------------------------
// tb_fsm_control_multi
// Two supervisors (ERR_EXIT_INIT = 0 and 1) share one stimulus stream and are
// each compared every cycle against a behavioural model of the supervisor.
// ----------------------------------------------------------------------------
module tb_fsm_control_multi;

  localparam int NF = 4;
  localparam int TW = 4;

  logic clk;
  logic rst;

  fsm_control_multi_if #(.NUM_FIFOS(NF), .TH_WIDTH(TW)) ifc0 ();
  fsm_control_multi_if #(.NUM_FIFOS(NF), .TH_WIDTH(TW)) ifc1 ();

  fsm_control_multi #(.NUM_FIFOS(NF), .TH_WIDTH(TW), .ERR_EXIT_INIT(1'b0)) dut0 (
    .clk(clk), .reset(rst), .bus(ifc0)
  );
  fsm_control_multi #(.NUM_FIFOS(NF), .TH_WIDTH(TW), .ERR_EXIT_INIT(1'b1)) dut1 (
    .clk(clk), .reset(rst), .bus(ifc1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Mode numbers are the published status codes: 0 reset, 1 init, 2 idle,
  // 3 active, 4 error.
  typedef struct {
    int         mode;
    logic [3:0] afull;
    logic [3:0] aempty;
    logic [3:0] src;
    bit         cfg;
  } mdl_t;

  mdl_t m0, m1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.mode = 0; m.afull = '0; m.aempty = '0; m.src = '0; m.cfg = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, bit may_leave_err, bit init,
                                    logic [3:0] ua, logic [3:0] ue,
                                    logic [3:0] ferr, logic [3:0] femp);
    mdl_t n = m;
    bit   fault     = (ferr != 4'd0);
    bit   all_empty = (femp == 4'hF);
    if (m.mode == 0) begin
      n.mode = 1;
    end else if (m.mode == 1) begin
      if (init) begin
        n.afull = ua; n.aempty = ue;
      end else if (int'(m.aempty) >= int'(m.afull)) begin
        n.mode = 4; n.cfg = 1'b1;
      end else begin
        n.mode = 2;
      end
    end else if (m.mode == 4) begin
      if (fault) n.src = m.src | ferr;
      else if (may_leave_err && init) begin
        n.mode = 1; n.src = '0; n.cfg = 1'b0;
      end
    end else begin
      if (fault)          begin n.mode = 4; n.src = ferr; end
      else if (init)      n.mode = 1;
      else if (all_empty) n.mode = 2;
      else                n.mode = 3;
    end
    return n;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_one(string tag, mdl_t m, logic [2:0] st, logic [3:0] af,
                         logic [3:0] ae, logic [3:0] src, logic idle,
                         logic active, logic err, logic cfg);
    chk({tag, ".state"},  {5'd0, st},  8'(m.mode));
    chk({tag, ".afull"},  {4'd0, af},  {4'd0, m.afull});
    chk({tag, ".aempty"}, {4'd0, ae},  {4'd0, m.aempty});
    chk({tag, ".src"},    {4'd0, src}, {4'd0, m.src});
    chk({tag, ".idle"},   {7'd0, idle},   {7'd0, (m.mode == 2)});
    chk({tag, ".active"}, {7'd0, active}, {7'd0, (m.mode == 3)});
    chk({tag, ".error"},  {7'd0, err},    {7'd0, (m.mode == 4)});
    chk({tag, ".cfg"},    {7'd0, cfg},    {7'd0, m.cfg});
  endtask

  task automatic check_all(string tag);
    chk_one({tag, "/d0"}, m0, ifc0.state, ifc0.umbrales_afull, ifc0.umbrales_aempty,
            ifc0.error_src, ifc0.idle, ifc0.active, ifc0.error, ifc0.cfg_err);
    chk_one({tag, "/d1"}, m1, ifc1.state, ifc1.umbrales_afull, ifc1.umbrales_aempty,
            ifc1.error_src, ifc1.idle, ifc1.active, ifc1.error, ifc1.cfg_err);
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; drives, lets one rising edge pass, checks,
  // and returns at the next falling edge.
  task automatic step(string tag, bit init, logic [3:0] ua, logic [3:0] ue,
                      logic [3:0] ferr, logic [3:0] femp);
    ifc0.init = init; ifc0.umbral_afull = ua; ifc0.umbral_aempty = ue;
    ifc0.FIFO_error = ferr; ifc0.FIFO_empty = femp;
    ifc1.init = init; ifc1.umbral_afull = ua; ifc1.umbral_aempty = ue;
    ifc1.FIFO_error = ferr; ifc1.FIFO_empty = femp;
    @(posedge clk);
    if (!rst) begin
      m0 = mdl_step(m0, 1'b0, init, ua, ue, ferr, femp);
      m1 = mdl_step(m1, 1'b1, init, ua, ue, ferr, femp);
    end
    #1 check_all(tag);
    @(negedge clk);
  endtask

  // Asserted away from the clock edge so the asynchronous path is exercised.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    m0 = mdl_reset(); m1 = mdl_reset();
    check_all("rst_async");
    @(posedge clk);
    #1 check_all("rst_hold");
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [3:0] ferr, femp;
    rst = 1'b1;
    m0 = mdl_reset(); m1 = mdl_reset();
    step("boot", 1'b0, 4'h0, 4'h0, 4'h0, 4'hF);
    rst = 1'b0;
    step("rel", 1'b0, 4'h0, 4'h0, 4'h0, 4'hF);
    chk("rel_state", {5'd0, ifc0.state}, 8'd1);

    // Program C/3 over two cycles, then validate.
    step("cfg1", 1'b1, 4'hC, 4'h3, 4'h0, 4'hF);
    step("cfg2", 1'b1, 4'hC, 4'h3, 4'h0, 4'hF);
    step("cfg_done", 1'b0, 4'h0, 4'h0, 4'h0, 4'hF);
    chk("t2_afull", {4'd0, ifc0.umbrales_afull}, 8'h0C);
    chk("t2_aempty", {4'd0, ifc0.umbrales_aempty}, 8'h03);
    chk("t2_idle", {7'd0, ifc0.idle}, 8'd1);

    // IDLE <-> ACTIVE on the empty flags.
    step("to_act", 1'b0, 4'h0, 4'h0, 4'h0, 4'b1011);
    chk("t3_active", {7'd0, ifc0.active}, 8'd1);
    step("to_idle", 1'b0, 4'h0, 4'h0, 4'h0, 4'hF);
    chk("t3_idle", {7'd0, ifc0.idle}, 8'd1);

    // Reset in the middle of ACTIVE.
    step("act_again", 1'b0, 4'h0, 4'h0, 4'h0, 4'b1011);
    do_reset();
    chk("t1_state0", {5'd0, ifc0.state}, 8'd0);
    step("t1_rel", 1'b0, 4'h0, 4'h0, 4'h0, 4'hF);
    chk("t1_state1", {5'd0, ifc0.state}, 8'd1);

    step("recfg", 1'b1, 4'hC, 4'h3, 4'h0, 4'hF);
    step("recfg_done", 1'b0, 4'h0, 4'h0, 4'h0, 4'hF);
    step("act3", 1'b0, 4'h0, 4'h0, 4'h0, 4'b1011);

    // FIFO errors: capture, then accumulate.
    step("err1", 1'b0, 4'h0, 4'h0, 4'b0100, 4'b1011);
    chk("t4_src1", {4'd0, ifc0.error_src}, 8'h04);
    chk("t4_err", {7'd0, ifc0.error}, 8'd1);
    step("err2", 1'b0, 4'h0, 4'h0, 4'b0001, 4'b1011);
    chk("t4_src2", {4'd0, ifc0.error_src}, 8'h05);
    step("err_init", 1'b1, 4'h0, 4'h0, 4'h0, 4'b1011);
    chk("t4_stays", {5'd0, ifc0.state}, 8'd4);
    chk("t5_leaves", {5'd0, ifc1.state}, 8'd1);
    chk("t5_src0", {4'd0, ifc1.error_src}, 8'h00);
    step("d1_idle", 1'b0, 4'h0, 4'h0, 4'h0, 4'hF);

    // Invalid thresholds 2/5.
    do_reset();
    step("bad_rel", 1'b0, 4'h0, 4'h0, 4'h0, 4'hF);
    step("bad_cfg", 1'b1, 4'h2, 4'h5, 4'h0, 4'hF);
    step("bad_done", 1'b0, 4'h0, 4'h0, 4'h0, 4'hF);
    chk("t6_cfg", {7'd0, ifc0.cfg_err}, 8'd1);
    chk("t6_src", {4'd0, ifc0.error_src}, 8'h00);
    chk("t6_afull", {4'd0, ifc0.umbrales_afull}, 8'h02);
    chk("t6_aempty", {4'd0, ifc0.umbrales_aempty}, 8'h05);
    step("bad_exit", 1'b1, 4'h8, 4'h1, 4'h0, 4'hF);

    // Random phase with periodic resets.
    for (int i = 0; i < 600; i++) begin
      if (i % 75 == 74) begin
        do_reset();
      end
      ferr = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      femp = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      step("rnd", ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), ferr, femp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
